// File: rtl/reg_writeback_queue.sv
// Writeback FIFO in front of the register bank: drains one entry per cycle to the bank
// write port and flags read hazards against pending writes. REG_WRITEBACK_FORWARDING_EN adds forwarding.
module reg_writeback_queue #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic              W,
  output logic [DATA_W-1:0] W_DATA,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              fwd_valid_a,
  output logic [DATA_W-1:0] fwd_data_a,
  output logic              fwd_valid_b,
  output logic [DATA_W-1:0] fwd_data_b
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic              w_match_a;
  logic              w_match_b;
  logic [PTR_W-1:0]  w_idx;

  assign w_nonempty = (r_count != '0);
  // in_ready is forced low while reset is held, independent of the (already cleared) count
  assign in_ready   = RST & (r_count != CNT_W'(DEPTH));
  assign W          = w_nonempty & ~hold;
  assign W_ADDR     = w_nonempty ? r_addr[r_rd_ptr] : '0;
  assign W_DATA     = w_nonempty ? r_data[r_rd_ptr] : '0;
  assign w_push     = in_valid & in_ready;
  assign w_pop      = W;

  // Pointer and occupancy state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; validity is tracked by r_count
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= in_addr;
      r_data[r_wr_ptr] <= in_data;
    end
  end

`ifdef REG_WRITEBACK_FORWARDING_EN
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  // Scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    w_match_a = 1'b0;
    w_match_b = 1'b0;
    w_fwd_a   = '0;
    w_fwd_b   = '0;
    w_idx     = r_rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if (r_addr[w_idx] == rd_addr_a) begin
          w_match_a = 1'b1;
          w_fwd_a   = r_data[w_idx];
        end
        if (r_addr[w_idx] == rd_addr_b) begin
          w_match_b = 1'b1;
          w_fwd_b   = r_data[w_idx];
        end
      end
    end
  end

  assign hazard_a    = 1'b0;
  assign hazard_b    = 1'b0;
  assign fwd_valid_a = w_match_a;
  assign fwd_valid_b = w_match_b;
  assign fwd_data_a  = w_fwd_a;
  assign fwd_data_b  = w_fwd_b;
`else
  // Any pending entry (including the head being written now) blocks the read
  always_comb begin
    w_match_a = 1'b0;
    w_match_b = 1'b0;
    w_idx     = r_rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if (r_addr[w_idx] == rd_addr_a) w_match_a = 1'b1;
        if (r_addr[w_idx] == rd_addr_b) w_match_b = 1'b1;
      end
    end
  end

  assign hazard_a    = w_match_a;
  assign hazard_b    = w_match_b;
  assign fwd_valid_a = 1'b0;
  assign fwd_valid_b = 1'b0;
  assign fwd_data_a  = '0;
  assign fwd_data_b  = '0;
`endif

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side front end of the processor register bank. Writeback results (address, data) from the pipeline go into a DEPTH-entry FIFO.
- The FIFO drains one entry per cycle into the bank write port (@W/W/DATA of the bank).
- Read addresses presented to the bank are checked against pending writes, producing hazard (stall) flags and, optionally, forwarded data.

Parameters:
- ADDR_W, 4, register address width (bank holds 2^ADDR_W registers)
- DATA_W, 8, register data width
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  asynchronous, active-low reset
- in_valid  input  1  writeback request present
- in_ready  output  1  queue can accept this cycle
- in_addr  input  ADDR_W  destination register
- in_data  input  DATA_W  value to write
- hold  input  1  freeze draining (bank busy / debug)
- W_ADDR  output  ADDR_W  to bank @W
- W  output  1  to bank write enable, active-high
- W_DATA  output  DATA_W  to bank DATA
- rd_addr_a  input  ADDR_W  bank read address A (@A)
- rd_addr_b  input  ADDR_W  bank read address B (@B)
- hazard_a  output  1  A must stall
- hazard_b  output  1  B must stall
- fwd_valid_a  output  1  forwarded data valid for A
- fwd_data_a  output  DATA_W  forwarded value for A
- fwd_valid_b  output  1  forwarded data valid for B
- fwd_data_b  output  DATA_W  forwarded value for B

Behaviour:
- State: DEPTH-entry storage, read pointer, write pointer (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- Reset values (RST low, immediate, asynchronous): count=0, pointers=0, W=0, in_ready=0 while RST is low. Storage contents are don't-care.
- Outputs after reset release with queue empty: W=0, hazards=0, fwd_valid=0, W_ADDR/W_DATA=0, in_ready=1.
- in_ready = (count != DEPTH), combinational from state only. It does not depend on a pop in the same cycle.
- Push: in_valid & in_ready at the edge. The entry is stored at the write pointer, which then increments.
- Pop:
  - W = (count != 0) & ~hold, combinational.
  - W_ADDR/W_DATA come from the head entry when count != 0, else 0.
  - The bank captures the write on the same edge that the head pops and the read pointer increments.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full with pop: in_ready is still 0 that cycle (no bypass).
- Latency: a request accepted at edge N drives W at edge N+1 at the earliest, provided the queue is empty and hold=0.
- Order: strict FIFO. Duplicate addresses are all written in order; the last one wins in the bank.
- hold=1: no pop, W=0, pushes still accepted until full.
- Hazard match:
  - An entry matches port A if it is valid (within count) and its stored addr equals rd_addr_a. Same rule for B.
  - The head entry being written this cycle still counts as matching; the bank is written at the edge, so the read is stale in this cycle.
  - An in-flight in_valid request that is not yet stored does not match.
- RST asserted mid-operation: all pending writes are discarded; W drops to 0 asynchronously.

Optional Feature:
- Macro: REG_WRITEBACK_FORWARDING_EN
- Defined:
  - On a match, fwd_valid_x=1 and fwd_data_x = data of the youngest matching entry (closest to the write pointer).
  - hazard_x=0 whenever fwd_valid_x=1. Hazards therefore never assert.
  - With no match, fwd_valid_x=0 and fwd_data_x=0.
- Undefined:
  - hazard_x = match.
  - fwd_valid_x and fwd_data_x are tied to 0. No forwarding mux is synthesized.

Test Plan:
1. Reset, then push (addr 3, data 0x5A) with hold=0 -> next cycle W=1, W_ADDR=3, W_DATA=0x5A; the following cycle W=0 and count=0.
2. hold=1, push 4 entries (1/0x11, 2/0x22, 3/0x33, 4/0x44) -> in_ready=0 after the 4th. A 5th push is refused and its data is never written. Release hold -> W asserted 4 consecutive cycles in order 1,2,3,4.
3. Full queue, hold=0, in_valid=1 -> first cycle pops addr 1 and refuses the push; next cycle pops addr 2 and accepts the push (count stays 3). Pointer wrap verified by the pushed entry draining 5th.
4. hold=1, push (5,0x10) then (5,0x20); rd_addr_a=5, rd_addr_b=6:
   - Without macro: hazard_a=1, hazard_b=0.
   - With macro: fwd_valid_a=1, fwd_data_a=0x20, hazard_a=0, fwd_valid_b=0.
5. Three entries pending, RST pulsed low mid-cycle -> W=0 and in_ready=0 immediately. After release: count=0, no writes emitted, hazards clear.
